// File: rtl/score_log.sv
// Per-channel ring of the last DEPTH scores with random-access read; SCORE_LOG_BEST_EN adds a since-clear best-score tracker.
// Latency: count/full/best update one edge after wr_stb; read result one cycle after rd_en, back-to-back reads supported.
// Backpressure: none; a write to a full channel overwrites the oldest entry (WRAP=1) or is dropped with an ovf pulse (WRAP=0).
module score_log #(
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 20,
   parameter int SCORE_W  = 10,
   parameter int WRAP     = 1,
   localparam int IW      = $clog2(DEPTH),
   localparam int CW      = $clog2(DEPTH + 1),
   localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic [CHANNELS-1:0]          wr_stb,
   input  logic [CHANNELS*SCORE_W-1:0]  wr_score,
   input  logic                         rd_en,
   input  logic [CHW-1:0]               rd_ch,
   input  logic [IW-1:0]                rd_idx,
   output logic [SCORE_W-1:0]           rd_data,
   output logic                         rd_valid,
   output logic                         rd_err,
   output logic [CHANNELS*CW-1:0]       count,
   output logic [CHANNELS-1:0]          full,
   output logic [CHANNELS-1:0]          ovf,
   output logic [CHANNELS*SCORE_W-1:0]  best,
   output logic [CHANNELS-1:0]          best_vld
);

   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
   localparam logic [IW-1:0]  LAST_PTR = IW'(DEPTH - 1);
   localparam logic [CHW:0]   NCH      = (CHW + 1)'(CHANNELS);
   localparam int             SW       = IW + 3;
   localparam logic [SW-1:0]  D1       = SW'(DEPTH);
   localparam logic [SW-1:0]  D2       = SW'(2 * DEPTH);

   logic [SCORE_W-1:0] mem    [CHANNELS][DEPTH];
   logic [IW-1:0]      wr_ptr [CHANNELS];
   logic [CW-1:0]      cnt    [CHANNELS];
   logic [SCORE_W-1:0] score  [CHANNELS];
   logic [CHANNELS-1:0] is_full;
   logic [CHANNELS-1:0] accept;

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         score[c]   = wr_score[c*SCORE_W +: SCORE_W];
         is_full[c] = (cnt[c] == FULL_CNT);
         accept[c]  = wr_stb[c] && !clr && ((WRAP != 0) || !is_full[c]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr[c] <= '0;
            cnt[c]    <= '0;
         end
         ovf <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (clr) begin
               wr_ptr[c] <= '0;
               cnt[c]    <= '0;
            end else if (accept[c]) begin
               wr_ptr[c] <= (wr_ptr[c] == LAST_PTR) ? '0 : wr_ptr[c] + 1'b1;
               if (!is_full[c])
                  cnt[c] <= cnt[c] + 1'b1;
            end
            ovf[c] <= wr_stb[c] && !clr && (WRAP == 0) && is_full[c];
         end
      end
   end

   // Storage is never cleared; entries past cnt are simply unreachable.
   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (accept[c])
            mem[c][wr_ptr[c]] <= score[c];
      end
   end

   logic               ch_ok;
   logic               rd_bad;
   logic [CHW-1:0]     rch;
   logic [SW-1:0]      sum;
   logic [SW-1:0]      wrapped;
   logic [IW-1:0]      slot;

   // Oldest entry sits at wr_ptr - cnt; adding DEPTH first keeps the sum non-negative.
   always_comb begin
      ch_ok   = ({1'b0, rd_ch} < NCH);
      rch     = ch_ok ? rd_ch : '0;
      rd_bad  = !ch_ok || (CW'(rd_idx) >= cnt[rch]);
      sum     = SW'(wr_ptr[rch]) + D1 - SW'(cnt[rch]) + SW'(rd_idx);
      wrapped = sum;
      if (sum >= D2)
         wrapped = sum - D2;
      else if (sum >= D1)
         wrapped = sum - D1;
      slot    = wrapped[IW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         rd_err   <= rd_en && rd_bad;
         if (rd_en)
            rd_data <= rd_bad ? '0 : mem[rch][slot];
      end
   end

   assign full = is_full;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt
      assign count[c*CW +: CW] = cnt[c];
   end

`ifdef SCORE_LOG_BEST_EN
   logic [SCORE_W-1:0]  best_q [CHANNELS];
   logic [CHANNELS-1:0] best_vld_q;

   // Since-clear minimum: overwritten or dropped entries never raise or touch it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CHANNELS; c++)
            best_q[c] <= '1;
         best_vld_q <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (clr) begin
               best_q[c]     <= '1;
               best_vld_q[c] <= 1'b0;
            end else if (accept[c] && (score[c] != '0) && (score[c] < best_q[c])) begin
               best_q[c]     <= score[c];
               best_vld_q[c] <= 1'b1;
            end
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_best
      assign best[c*SCORE_W +: SCORE_W] = best_q[c];
   end
   assign best_vld = best_vld_q;
`else
   assign best     = '1;
   assign best_vld = '0;
`endif

endmodule

// File: tb/tb_score_log.sv
// Bench for score_log: two instances (default ring, and a 3-channel depth-4 drop-on-full log) against a queue-based model.
module tb_score_log;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

`ifdef SCORE_LOG_BEST_EN
   localparam bit BEST_ON = 1'b1;
`else
   localparam bit BEST_ON = 1'b0;
`endif

   // Instance A: CHANNELS=2, DEPTH=20, WRAP=1
   logic        a_clr, a_rd_en;
   logic [1:0]  a_wr_stb;
   logic [19:0] a_wr_score;
   logic [0:0]  a_rd_ch;
   logic [4:0]  a_rd_idx;
   logic [9:0]  a_rd_data;
   logic        a_rd_valid, a_rd_err;
   logic [9:0]  a_count;
   logic [1:0]  a_full, a_ovf, a_best_vld;
   logic [19:0] a_best;

   // Instance B: CHANNELS=3, DEPTH=4, WRAP=0
   logic        b_clr, b_rd_en;
   logic [2:0]  b_wr_stb;
   logic [29:0] b_wr_score;
   logic [1:0]  b_rd_ch, b_rd_idx;
   logic [9:0]  b_rd_data;
   logic        b_rd_valid, b_rd_err;
   logic [8:0]  b_count;
   logic [2:0]  b_full, b_ovf, b_best_vld;
   logic [29:0] b_best;

   score_log u_a (
      .clk(clk), .rst_n(rst_n), .clr(a_clr), .wr_stb(a_wr_stb), .wr_score(a_wr_score),
      .rd_en(a_rd_en), .rd_ch(a_rd_ch), .rd_idx(a_rd_idx), .rd_data(a_rd_data),
      .rd_valid(a_rd_valid), .rd_err(a_rd_err), .count(a_count), .full(a_full),
      .ovf(a_ovf), .best(a_best), .best_vld(a_best_vld));

   score_log #(.CHANNELS(3), .DEPTH(4), .SCORE_W(10), .WRAP(0)) u_b (
      .clk(clk), .rst_n(rst_n), .clr(b_clr), .wr_stb(b_wr_stb), .wr_score(b_wr_score),
      .rd_en(b_rd_en), .rd_ch(b_rd_ch), .rd_idx(b_rd_idx), .rd_data(b_rd_data),
      .rd_valid(b_rd_valid), .rd_err(b_rd_err), .count(b_count), .full(b_full),
      .ovf(b_ovf), .best(b_best), .best_vld(b_best_vld));

   // Reference model: each channel is a queue of stored scores, oldest first.
   int dep [2] = '{20, 4};
   bit wrp [2] = '{1'b1, 1'b0};
   int nch [2] = '{2, 3};
   int hist [2][3][$];
   int m_best [2][3];
   bit m_bv [2][3];
   bit m_ovf [2][3];
   bit m_rv [2];
   bit m_re [2];
   int m_rd [2];

   int ncmp = 0;
   int nerr = 0;
   bit chk_on = 1'b0;

   task automatic chk(string nm, int act, int exp);
      ncmp++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mreset();
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < 3; c++) begin
            hist[i][c].delete();
            m_best[i][c] = 1023;
            m_bv[i][c]   = 1'b0;
            m_ovf[i][c]  = 1'b0;
         end
         m_rv[i] = 1'b0;
         m_re[i] = 1'b0;
         m_rd[i] = 0;
      end
   endtask

   task automatic mstep(int i, bit [2:0] stb, bit [29:0] sc, bit clr, bit ren, int ch, int idx);
      int s;
      bit take;
      m_rv[i] = ren;
      m_re[i] = 1'b0;
      if (ren) begin
         if (ch >= nch[i] || idx >= hist[i][ch].size()) begin
            m_re[i] = 1'b1;
            m_rd[i] = 0;
         end else begin
            m_rd[i] = hist[i][ch][idx];
         end
      end
      for (int c = 0; c < 3; c++)
         m_ovf[i][c] = 1'b0;
      for (int c = 0; c < nch[i]; c++) begin
         s = int'(sc[c*10 +: 10]);
         if (clr) begin
            hist[i][c].delete();
            m_best[i][c] = 1023;
            m_bv[i][c]   = 1'b0;
         end else if (stb[c]) begin
            take = 1'b1;
            if (hist[i][c].size() == dep[i]) begin
               if (wrp[i]) void'(hist[i][c].pop_front());
               else begin
                  take = 1'b0;
                  m_ovf[i][c] = 1'b1;
               end
            end
            if (take) begin
               hist[i][c].push_back(s);
               if (BEST_ON && s != 0 && s < m_best[i][c]) begin
                  m_best[i][c] = s;
                  m_bv[i][c]   = 1'b1;
               end
            end
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mreset();
      else begin
         mstep(0, {1'b0, a_wr_stb}, {10'd0, a_wr_score}, a_clr, a_rd_en, int'(a_rd_ch), int'(a_rd_idx));
         mstep(1, b_wr_stb, b_wr_score, b_clr, b_rd_en, int'(b_rd_ch), int'(b_rd_idx));
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int c = 0; c < 2; c++) begin
            chk("a_count", int'(a_count[c*5 +: 5]), hist[0][c].size());
            chk("a_full", int'(a_full[c]), int'(hist[0][c].size() == 20));
            chk("a_ovf", int'(a_ovf[c]), int'(m_ovf[0][c]));
            chk("a_best", int'(a_best[c*10 +: 10]), m_best[0][c]);
            chk("a_best_vld", int'(a_best_vld[c]), int'(m_bv[0][c]));
         end
         for (int c = 0; c < 3; c++) begin
            chk("b_count", int'(b_count[c*3 +: 3]), hist[1][c].size());
            chk("b_full", int'(b_full[c]), int'(hist[1][c].size() == 4));
            chk("b_ovf", int'(b_ovf[c]), int'(m_ovf[1][c]));
            chk("b_best", int'(b_best[c*10 +: 10]), m_best[1][c]);
            chk("b_best_vld", int'(b_best_vld[c]), int'(m_bv[1][c]));
         end
         chk("a_rd_valid", int'(a_rd_valid), int'(m_rv[0]));
         chk("a_rd_err", int'(a_rd_err), int'(m_re[0]));
         chk("a_rd_data", int'(a_rd_data), m_rd[0]);
         chk("b_rd_valid", int'(b_rd_valid), int'(m_rv[1]));
         chk("b_rd_err", int'(b_rd_err), int'(m_re[1]));
         chk("b_rd_data", int'(b_rd_data), m_rd[1]);
      end
   end

   task automatic idle();
      a_clr = 1'b0; a_wr_stb = '0; a_wr_score = '0; a_rd_en = 1'b0; a_rd_ch = '0; a_rd_idx = '0;
      b_clr = 1'b0; b_wr_stb = '0; b_wr_score = '0; b_rd_en = 1'b0; b_rd_ch = '0; b_rd_idx = '0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic a_write(int c, int s);
      a_wr_stb[c] = 1'b1;
      a_wr_score[c*10 +: 10] = 10'(s);
      step();
      idle();
   endtask

   task automatic b_write(int c, int s);
      b_wr_stb[c] = 1'b1;
      b_wr_score[c*10 +: 10] = 10'(s);
      step();
      idle();
   endtask

   task automatic a_read(int ch, int idx);
      a_rd_en = 1'b1; a_rd_ch = 1'(ch); a_rd_idx = 5'(idx);
      step();
      idle();
   endtask

   task automatic b_read(int ch, int idx);
      b_rd_en = 1'b1; b_rd_ch = 2'(ch); b_rd_idx = 2'(idx);
      step();
      idle();
   endtask

   function automatic logic [9:0] rscore();
      return ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
   endfunction

   initial begin
      idle();
      mreset();
      repeat (2) @(negedge clk);
      chk("rst_a_count", int'(a_count), 0);
      chk("rst_a_best", int'(a_best), 20'hFFFFF);
      chk("rst_a_best_vld", int'(a_best_vld), 0);
      chk("rst_a_rd_valid", int'(a_rd_valid), 0);
      chk("rst_a_rd_data", int'(a_rd_data), 0);
      chk("rst_b_full", int'(b_full), 0);
      rst_n = 1'b1;
      chk_on = 1'b1;
      step();

      // basic write then read-back, index past count
      a_write(0, 100); a_write(0, 200); a_write(0, 300);
      a_read(0, 0); chk("t1_idx0", int'(a_rd_data), 100); chk("t1_vld", int'(a_rd_valid), 1);
      a_read(0, 1); chk("t1_idx1", int'(a_rd_data), 200);
      a_read(0, 2); chk("t1_idx2", int'(a_rd_data), 300);
      a_read(0, 3); chk("t1_idx3_err", int'(a_rd_err), 1); chk("t1_idx3_data", int'(a_rd_data), 0);
      chk("t1_count0", int'(a_count[4:0]), 3);
      chk("t1_count1", int'(a_count[9:5]), 0);
      step(); chk("t1_vld_drop", int'(a_rd_valid), 0);

      // wrap on full channel
      a_clr = 1'b1; step(); idle();
      for (int k = 1; k <= 25; k++) begin
         a_write(1, k);
         chk("t2_ovf", int'(a_ovf), 0);
      end
      chk("t2_count", int'(a_count[9:5]), 20);
      chk("t2_full", int'(a_full[1]), 1);
      a_read(1, 0);  chk("t2_idx0", int'(a_rd_data), 6);
      a_read(1, 19); chk("t2_idx19", int'(a_rd_data), 25);
      a_read(1, 20); chk("t2_idx20_err", int'(a_rd_err), 1);

      // drop on full channel
      for (int k = 1; k <= 5; k++) begin
         b_write(0, k * 10);
         chk("t3_ovf", int'(b_ovf), (k == 5) ? 1 : 0);
      end
      chk("t3_count", int'(b_count[2:0]), 4);
      b_read(0, 3); chk("t3_idx3", int'(b_rd_data), 40);
      chk("t3_ovf_pulse", int'(b_ovf), 0);
      b_read(3, 0); chk("t3_badch_err", int'(b_rd_err), 1); chk("t3_badch_data", int'(b_rd_data), 0);
      b_read(2, 0); chk("t3_empty_err", int'(b_rd_err), 1);

      // simultaneous writes with same-cycle read of the old state
      a_clr = 1'b1; step(); idle();
      a_wr_stb = 2'b11; a_wr_score = {10'd9, 10'd7};
      a_rd_en = 1'b1; a_rd_ch = 1'b0; a_rd_idx = 5'd0;
      step(); idle();
      chk("t4_err", int'(a_rd_err), 1); chk("t4_data", int'(a_rd_data), 0);
      chk("t4_count0", int'(a_count[4:0]), 1); chk("t4_count1", int'(a_count[9:5]), 1);
      a_read(1, 0); chk("t4_ch1", int'(a_rd_data), 9);

      // clr wins over a same-cycle write
      a_write(0, 55);
      a_clr = 1'b1; a_wr_stb = 2'b01; a_wr_score[9:0] = 10'd5;
      step(); idle();
      chk("t5_count", int'(a_count[4:0]), 0);
      chk("t5_best_vld", int'(a_best_vld[0]), 0);
      chk("t5_best", int'(a_best[9:0]), 1023);
      a_read(0, 0); chk("t5_err", int'(a_rd_err), 1);

      // best tracker ignores zero scores
      a_write(0, 300); a_write(0, 0); a_write(0, 150); a_write(0, 220);
      chk("t6_best", int'(a_best[9:0]), BEST_ON ? 150 : 1023);
      chk("t6_best_vld", int'(a_best_vld[0]), BEST_ON ? 1 : 0);

      // reset while a read result is showing
      a_rd_en = 1'b1; a_rd_ch = 1'b0; a_rd_idx = 5'd2;
      step();
      chk("t7_pre_vld", int'(a_rd_valid), 1); chk("t7_pre_data", int'(a_rd_data), 150);
      #1 rst_n = 1'b0;
      #1;
      chk("t7_vld_drop", int'(a_rd_valid), 0);
      chk("t7_count", int'(a_count), 0);
      idle();
      step();
      rst_n = 1'b1;
      step();
      chk("t7_no_late", int'(a_rd_valid), 0);

      for (int n = 0; n < 1500; n++) begin
         a_wr_stb   = 2'($urandom);
         a_wr_score = {rscore(), rscore()};
         a_clr      = ($urandom_range(0, 199) == 0);
         a_rd_en    = 1'($urandom);
         a_rd_ch    = 1'($urandom);
         a_rd_idx   = 5'($urandom_range(0, 22));
         b_wr_stb   = 3'($urandom);
         b_wr_score = {rscore(), rscore(), rscore()};
         b_clr      = ($urandom_range(0, 99) == 0);
         b_rd_en    = 1'($urandom);
         b_rd_ch    = 2'($urandom);
         b_rd_idx   = 2'($urandom);
         step();
      end
      idle();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/score_log.md
# score_log

Per-channel score history buffer for the reaction-timer game, and the parametrised successor to the fixed two-player, nine-entry score store. Each channel keeps a ring of the last DEPTH scores with per-channel counts, wrap or drop overflow handling, and a synchronous random-access read port for the display and scan logic. An optional best-score tracker reports each channel's fastest non-zero reaction time since the last clear.

## Interface

Parameters:
- CHANNELS, 2: number of independent players/channels (≥1).
- DEPTH, 20: entries per channel (≥2).
- SCORE_W, 10: score width in bits.
- WRAP, 1: 1 means a write to a full channel overwrites the oldest entry; 0 means the write is dropped and `ovf` pulses.
- Derived: IW = clog2(DEPTH), CW = clog2(DEPTH+1), CHW = max(1, clog2(CHANNELS)).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of all channels (new match).
- wr_stb  in  CHANNELS  one-cycle write pulse per channel.
- wr_score  in  CHANNELS*SCORE_W  channel c occupies bits [c*SCORE_W +: SCORE_W].
- rd_en  in  1  read request.
- rd_ch  in  CHW  channel to read.
- rd_idx  in  IW  logical index; 0 = oldest stored entry.
- rd_data  out  SCORE_W  read result.
- rd_valid  out  1  read result valid; one-cycle pulse.
- rd_err  out  1  with rd_valid: the index or channel was out of range.
- count  out  CHANNELS*CW  stored entries per channel.
- full  out  CHANNELS  count equals DEPTH.
- ovf  out  CHANNELS  one-cycle pulse when a write is dropped (WRAP=0).
- best  out  CHANNELS*SCORE_W  minimum non-zero score per channel.
- best_vld  out  CHANNELS  best holds a real value.

## Operation

- Per channel c, registers: wr_ptr (IW bits) and cnt (CW bits). Memory is CHANNELS×DEPTH×SCORE_W.
- Write when wr_stb[c]=1 and clr=0:
  - Store the score at wr_ptr.
  - Advance wr_ptr: DEPTH-1 wraps to 0.
  - cnt increments and saturates at DEPTH.
- Full channel with WRAP=1: the write proceeds and the oldest entry is lost; cnt stays at DEPTH.
- Full channel with WRAP=0: the write is ignored, wr_ptr and cnt are unchanged, and ovf[c]=1 for one cycle.
- Simultaneous writes on different channels are independent and all succeed.
- Read: the physical slot is (wr_ptr − cnt + rd_idx) mod DEPTH, computed without negative intermediates.
- If rd_idx ≥ cnt[rd_ch] or rd_ch ≥ CHANNELS: rd_data=0 and rd_err=1.
- Score 0 (no press / foul) is stored and counted, but never updates best.
- clr:
  - Zeroes every wr_ptr, cnt and ovf, clears best_vld, and sets best to all-ones.
  - Memory contents are not cleared; they are unreachable because cnt=0.
  - clr takes priority over wr_stb in the same cycle, and that write is lost.
- Read in the same cycle as a write to the same channel returns pre-write state (old cnt and wr_ptr).

## Timing

- Reset (rst_n=0, asynchronous) sets:
  - rd_data=0, rd_valid=0, rd_err=0
  - all count=0, full=0, ovf=0
  - best=all-ones, best_vld=0
  - all pointers = 0.
- Write latency: count, full and best update on the edge after wr_stb. A read issued the next cycle sees the new entry.
- Read latency: one cycle. rd_en sampled high at edge N gives rd_valid/rd_data/rd_err at edge N+1. rd_valid=0 otherwise and rd_data holds its last value.
- Back-to-back reads every cycle are supported, with no stall.
- Reset asserted mid-read: rd_valid drops immediately, and no pending result is delivered after release.
- count and full are registered; ovf is a registered one-cycle pulse.

## Configuration

- SCORE_LOG_BEST_EN defined:
  - per-channel best register.
  - On an accepted non-zero write with score < best: best=score and best_vld=1.
  - Dropped writes never update best.
  - Overwritten entries do not raise best; it is a since-clear minimum.
- Not defined: no best registers are built; best is tied to all-ones and best_vld to 0.

## Test plan

- Reset then defaults: CHANNELS=2, DEPTH=20. Write ch0 scores 100, 200, 300, then read idx 0..3. Expect 100, 200, 300, then rd_err=1 with rd_data=0, each one cycle after rd_en. count[0]=3, count[1]=0.
- WRAP=1: write 25 scores 1..25 to ch1. Expect count=20 and full=1. idx0 reads 6, idx19 reads 25, and ovf never pulses.
- WRAP=0: DEPTH=4, write 5 scores 10..50. Expect a 5th-cycle ovf[0] pulse, count=4, and idx3 reads 40.
- Same-cycle wr_stb=2'b11 with scores 7/9 plus rd_en on ch0 idx0 (empty). Expect rd_err=1, then both counts =1. Next read of ch1 idx0 returns 9.
- clr together with wr_stb[0]: count[0]=0, best_vld=0, and a read of idx0 gives rd_err.
- SCORE_LOG_BEST_EN: ch0 writes 300, 0, 150, 220. Expect best[0]=150 and best_vld[0]=1. Without the macro: best=all-ones and best_vld=0.
